bin2bcd_stream: RTL
===================

Name: bin2bcd_stream

Overview:
Parametrised iterative binary-to-BCD converter (shift-and-add-3) with valid/ready handshakes on input and output.
Successor to the fixed-width double-dabble converter. Adds:
- generic WIDTH and DIGITS
- backpressure on both sides
- overflow detection
- significant-digit count for display blanking

Sits between arithmetic datapaths and seven-segment / UART formatting blocks.

Parameters:
- WIDTH, 16, binary input width in bits; legal range >= 2.
- DIGITS, 5, number of BCD output digits; legal range >= 1.

Ports:
- clk  input  1  clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept a new operand.
- in_data  input  WIDTH  binary operand (unsigned unless BIN2BCD_SIGNED_EN).
- out_valid  output  1  result outputs are valid.
- out_ready  input  1  consumer accepts the result.
- digits  output  4*DIGITS  BCD result; digit 0 = LSD in bits [3:0].
- ndigits  output  $clog2(DIGITS+1)  count of significant digits (1..DIGITS).
- overflow  output  1  result did not fit in DIGITS digits.
- negative  output  1  sign of operand (tied 0 when BIN2BCD_SIGNED_EN undefined).

Behaviour:
- One clock; reset is synchronous and active-high: clk, reset.
- Reset values:
  - state=IDLE, in_ready=1, out_valid=0
  - digits=0, ndigits=1, overflow=0, negative=0
  - internal shift/counter registers=0
- Reset asserted in any state aborts the conversion; no partial result is ever presented.
- States:
  - IDLE: in_ready=1. On in_valid&in_ready:
    - capture operand into the shift register
    - clear the BCD accumulator and overflow
    - counter=0
    - go to SHIFT
  - SHIFT: in_ready=0, out_valid=0. Each cycle:
    - every 4-bit digit >=5 gets +3
    - then the concatenation {accumulator, operand} shifts left by 1; the operand MSB enters digit 0 bit 0
    - a 1 shifted out of the top digit sets overflow (sticky until the next accept)
    - after WIDTH shift cycles (counter==WIDTH-1 on the last), go to DONE
  - DONE: out_valid=1; digits, ndigits, overflow and negative are held stable. On out_ready, go to IDLE.
- Latency:
  - out_valid rises on the edge WIDTH cycles after the accepting edge.
  - With out_ready held 1, throughput is one conversion per WIDTH+2 cycles.
- in_ready is high in IDLE only; it is not combinationally dependent on out_ready.
- in_valid while not in IDLE is ignored; the operand is not latched.
- Outputs change only on entering DONE. During IDLE and SHIFT they keep the last result; out_valid qualifies them.
- ndigits:
  - index of the highest nonzero digit +1
  - 1 when all digits are zero
  - DIGITS when overflow=1
  - registered together with digits on entry to DONE
- Overflow result: digits hold the low DIGITS digits of the true BCD value, i.e. the value mod 10^DIGITS.
- Counter width is $clog2(WIDTH)+1, so WIDTH equal to a power of two does not wrap early.

Optional Feature:
Macro: BIN2BCD_SIGNED_EN

Defined:
- in_data is two's complement.
- On accept:
  - negative = in_data[WIDTH-1]
  - the shift register loads |in_data|, computed in WIDTH bits as an unsigned magnitude
  - the most-negative value yields magnitude 2^(WIDTH-1) correctly
- Conversion proceeds on the magnitude.
- negative is presented in DONE; it is 0 for zero input.

Undefined:
- Operand is unsigned and negative is constant 0.
- No sign/negate logic is synthesised.

Test Plan:
1. WIDTH=16, DIGITS=5, in_data=0, out_ready=1 -> out_valid exactly 16 cycles after accept; digits=0x00000, ndigits=1, overflow=0.
2. WIDTH=16, DIGITS=5, in_data=65535 -> digits=0x65535, ndigits=5, overflow=0. Back-to-back operands 1, 9, 10, 99999-mod-fit values (e.g. 12345) -> correct BCD; accepts spaced exactly WIDTH+2 cycles.
3. WIDTH=8, DIGITS=2, in_data=255 -> overflow=1, digits=0x55, ndigits=2. Next operand 42 -> overflow=0, digits=0x42.
4. Backpressure: result 0x01234 held with out_ready=0 for 10 cycles -> digits/out_valid stable, in_ready=0, in_valid pulses ignored. Then out_ready=1 -> IDLE next cycle, in_ready=1.
5. Reset mid-SHIFT (cycle 7 of 16) -> next cycle state IDLE, out_valid=0, digits=0, in_ready=1. A fresh conversion of 500 gives 0x00500.
6. BIN2BCD_SIGNED_EN, WIDTH=16:
   - -1234 -> negative=1, digits=0x01234, ndigits=4
   - -32768 -> negative=1, digits=0x32768
   - 0 -> negative=0

Source files
------------

// File: rtl/bin2bcd_stream.sv
// Iterative shift-and-add-3 binary-to-BCD converter with valid/ready on both sides.
// Optional two's-complement operand support under `define BIN2BCD_SIGNED_EN.
module bin2bcd_stream #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [WIDTH-1:0]                 in_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [4*DIGITS-1:0]              digits,
  output logic [$clog2(DIGITS+1)-1:0]      ndigits,
  output logic                             overflow,
  output logic                             negative
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam int NW = $clog2(DIGITS + 1);
  localparam int DW = 4 * DIGITS;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] op_q, op_d;
  logic [DW-1:0]    acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [DW-1:0]    dig_q, dig_d;
  logic [NW-1:0]    nd_q, nd_d;
  logic             oflow_q, oflow_d;

  logic [DW-1:0]    adj;
  logic [DW-1:0]    acc_sh;
  logic [WIDTH-1:0] op_sh;
  logic             ovf_sh;
  logic [NW-1:0]    nd_calc;
  logic [WIDTH-1:0] mag;

`ifdef BIN2BCD_SIGNED_EN
  logic sign_q, sign_d;
  logic neg_q, neg_d;

  // Negating the most-negative value wraps to 2^(WIDTH-1), which is the
  // correct unsigned magnitude.
  assign mag = in_data[WIDTH-1] ? (~in_data + WIDTH'(1)) : in_data;
  assign negative = neg_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sign_q <= 1'b0;
      neg_q  <= 1'b0;
    end else begin
      sign_q <= sign_d;
      neg_q  <= neg_d;
    end
  end

  always_comb begin
    sign_d = sign_q;
    neg_d  = neg_q;
    if (state_q == S_IDLE && in_valid)
      sign_d = in_data[WIDTH-1];
    if (state_q == S_SHIFT && cnt_q == CW'(WIDTH - 1))
      neg_d = sign_q;
  end
`else
  assign mag = in_data;
  assign negative = 1'b0;
`endif

  always_comb begin
    adj = '0;
    for (int i = 0; i < DIGITS; i++) begin
      adj[4*i +: 4] = (acc_q[4*i +: 4] >= 4'd5) ?
                      acc_q[4*i +: 4] + 4'd3 : acc_q[4*i +: 4];
    end
  end

  // A 1 leaving the top digit means the value no longer fits.
  assign acc_sh = {adj[DW-2:0], op_q[WIDTH-1]};
  assign op_sh  = {op_q[WIDTH-2:0], 1'b0};
  assign ovf_sh = ovf_q | adj[DW-1];

  always_comb begin
    nd_calc = NW'(1);
    for (int i = 0; i < DIGITS; i++) begin
      if (acc_sh[4*i +: 4] != 4'd0)
        nd_calc = NW'(i + 1);
    end
    if (ovf_sh)
      nd_calc = NW'(DIGITS);
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    dig_d   = dig_q;
    nd_d    = nd_q;
    oflow_d = oflow_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          op_d    = mag;
          acc_d   = '0;
          ovf_d   = 1'b0;
          cnt_d   = '0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        op_d  = op_sh;
        acc_d = acc_sh;
        ovf_d = ovf_sh;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = S_DONE;
          dig_d   = acc_sh;
          nd_d    = nd_calc;
          oflow_d = ovf_sh;
        end
      end
      S_DONE: begin
        if (out_ready)
          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      dig_q   <= '0;
      nd_q    <= NW'(1);
      oflow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      dig_q   <= dig_d;
      nd_q    <= nd_d;
      oflow_q <= oflow_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign digits    = dig_q;
  assign ndigits   = nd_q;
  assign overflow  = oflow_q;

endmodule
